// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// rr_pick scans req starting at ptr and returns the first set index or -1.
package fifo_arb_pkg;

  localparam int MAXN = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_BURST = ST_BURST;

  function automatic int rr_pick(
    input logic [MAXN-1:0] req,
    input int              n,
    input int              ptr
  );
    int j;
    int r;
    r = -1;
    // walk backwards so the closest hit to ptr wins
    for (int k = MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[5'(j)]) r = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter.
// slave = arbiter side, master = producers and FIFO consumer.
interface fifo_wr_arbiter_if #(
  parameter int N    = 4,
  parameter int DATA = 8,
  parameter int ADDR = 4
);
  logic [N-1:0]      req;
  logic [N*DATA-1:0] din_bus;
  logic [N-1:0]      gnt;
  logic              fifo_wr_en;
  logic [DATA-1:0]   fifo_din;
  logic              fifo_rd_en;
  logic [ADDR:0]     level;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output req, din_bus, fifo_rd_en,
    input  gnt, fifo_wr_en, fifo_din,
    input  level, full, empty, err
  );

  modport slave (
    input  req, din_bus, fifo_rd_en,
    output gnt, fifo_wr_en, fifo_din,
    output level, full, empty, err
  );
endinterface

// File: rtl/fifo_level_ctr.sv
// Credit counter mirroring syn_fifo occupancy.
// err is sticky once a read is seen on an empty FIFO.
module fifo_level_ctr #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic          rd_i,
  output logic [ADDR:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  logic [ADDR:0] level_q, level_d;
  logic          err_q, err_d;

  always_comb begin
    level_d = level_q;
    err_d   = err_q | (rd_i && level_q == '0);
    unique case (1'b1)
      wr_i && !rd_i:
        level_d = level_q + 1'b1;
      !wr_i && rd_i && level_q != '0:
        level_d = level_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  assign level_o = level_q;
  assign full_o  = level_q == (ADDR+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign err_o   = err_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts in front of syn_fifo.
// Grants are combinational and never issued while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DATA  = 8,
  parameter int ADDR  = 4,
  parameter int DEPTH = 16,
  parameter int BURST = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(BURST + 1);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [N-1:0]  gnt, gnt_m;
  logic [DATA-1:0] din;
  logic          wr_en;
  logic          full_w;
  int            pick_i;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i
  );
    return IW'((int'(i) + 1) % N);
  endfunction

  assign pick_i = rr_pick(MAXN'(bus.req), N, int'(rr_ptr_q));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    gnt      = '0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        for (int i = 0; i < N; i++) begin
          if (!full_w && pick_i == i) begin
            gnt[i] = 1'b1;
            if (BURST == 1) begin
              rr_ptr_d = nxt(IW'(i));
            end else begin
              state_d = S_BURST;
              owner_d = IW'(i);
              beat_d  = BW'(1);
            end
          end
        end
      end
      state_q == S_BURST: begin
        if (!bus.req[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = nxt(owner_q);
          beat_d   = '0;
        end else if (!full_w) begin
          gnt[owner_q] = 1'b1;
          beat_d       = BW'(beat_q + 1'b1);
          if (int'(beat_q) + 1 == BURST) begin
            state_d  = S_IDLE;
            rr_ptr_d = nxt(owner_q);
            beat_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

  // keep the port quiet while reset is held
  assign gnt_m = rst ? gnt : '0;
  assign wr_en = |(bus.req & gnt_m);

  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_m[i]) din = bus.din_bus[i*DATA +: DATA];
    end
  end

  fifo_level_ctr #(
    .ADDR  (ADDR),
    .DEPTH (DEPTH)
  ) u_level (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wr_en),
    .rd_i    (bus.fifo_rd_en),
    .level_o (bus.level),
    .full_o  (full_w),
    .empty_o (bus.empty),
    .err_o   (bus.err)
  );

  assign bus.full       = full_w;
  assign bus.gnt        = gnt_m;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = din;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, corner sequences, random
// traffic against a holder/beat-count model and a data scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DATA  = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(N), .DATA(DATA), .ADDR(ADDR)) bus ();

  fifo_wr_arbiter #(
    .N(N), .DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  int m_level, m_holder, m_beats, m_ptr;
  bit m_err;
  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] got_q[$];

  logic [N-1:0] obs_gnt;
  logic [ADDR:0] obs_level;
  logic obs_full, obs_err;

  typedef struct {
    logic [N-1:0]  req;
    logic          rd;
    logic [N-1:0]  gnt;
    logic [ADDR:0] level;
  } row_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_grant(input logic [N-1:0] r);
    if (m_level >= DEPTH) return -1;
    if (m_holder >= 0) return r[m_holder] ? m_holder : -1;
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_level = 0; m_err = 0; m_holder = -1; m_beats = 0; m_ptr = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic rd);
    int g;
    logic [N-1:0] eg;
    logic [DATA-1:0] ed;
    logic [N*DATA-1:0] d;
    logic [DATA-1:0] e, a;
    @(negedge clk);
    d = $urandom;
    bus.req = r;
    bus.fifo_rd_en = rd;
    bus.din_bus = d;
    #1;
    g = m_grant(r);
    eg = '0;
    ed = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ed = d[g*DATA +: DATA];
    end
    obs_gnt = bus.gnt;
    obs_level = bus.level;
    obs_full = bus.full;
    obs_err = bus.err;
    chk("gnt", bus.gnt, eg);
    chk("wr_en", bus.fifo_wr_en, g >= 0);
    chk("din", bus.fifo_din, ed);
    chk("level", bus.level, m_level);
    chk("full", bus.full, m_level == DEPTH);
    chk("empty", bus.empty, m_level == 0);
    chk("err", bus.err, m_err);
    if (rd && m_level > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk("dout", a, e);
    end
    if (g >= 0) exp_q.push_back(ed);
    if (bus.fifo_wr_en) got_q.push_back(bus.fifo_din);
    @(posedge clk);
    if (rd && m_level == 0) m_err = 1;
    if (g >= 0 && !rd) m_level++;
    else if (g < 0 && rd && m_level > 0) m_level--;
    if (m_holder >= 0) begin
      if (!r[m_holder]) begin
        m_ptr = (m_holder + 1) % N;
        m_holder = -1;
      end else if (g >= 0) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_ptr = (m_holder + 1) % N;
          m_holder = -1;
        end
      end
    end else if (g >= 0) begin
      if (BURST == 1) m_ptr = (g + 1) % N;
      else begin
        m_holder = g;
        m_beats = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = '1;
    bus.fifo_rd_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_din", bus.fifo_din, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    model_reset();
  endtask

  row_t tbl[17];

  initial begin
    bus.req = '0;
    bus.din_bus = '0;
    bus.fifo_rd_en = 1'b0;
    model_reset();

    tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 5'd0};
    tbl[1]  = '{4'b1000, 1'b1, 4'b0000, 5'd1};
    tbl[2]  = '{4'b1010, 1'b0, 4'b1000, 5'd0};
    tbl[3]  = '{4'b0010, 1'b1, 4'b0000, 5'd1};
    tbl[4]  = '{4'b1010, 1'b0, 4'b0010, 5'd0};
    tbl[5]  = '{4'b1000, 1'b1, 4'b0000, 5'd1};
    tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 5'd0};
    tbl[7]  = '{4'b0010, 1'b1, 4'b0000, 5'd1};
    tbl[8]  = '{4'b0011, 1'b0, 4'b0001, 5'd0};
    tbl[9]  = '{4'b0011, 1'b0, 4'b0001, 5'd1};
    tbl[10] = '{4'b0011, 1'b0, 4'b0001, 5'd2};
    tbl[11] = '{4'b0011, 1'b0, 4'b0001, 5'd3};
    tbl[12] = '{4'b0011, 1'b0, 4'b0010, 5'd4};
    tbl[13] = '{4'b0011, 1'b0, 4'b0010, 5'd5};
    tbl[14] = '{4'b0011, 1'b0, 4'b0010, 5'd6};
    tbl[15] = '{4'b0011, 1'b0, 4'b0010, 5'd7};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 5'd8};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].req, tbl[i].rd);
      chk($sformatf("tbl%0d_gnt", i), obs_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_level", i), obs_level, tbl[i].level);
    end

    // fill to full, then stall, then one read frees one slot
    repeat (8) cycle(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 1'b0);
      chk("stall_gnt", obs_gnt, 0);
      chk("stall_level", obs_level, 16);
      chk("stall_full", obs_full, 1);
    end
    cycle(4'hF, 1'b1);
    chk("rd_full_gnt", obs_gnt, 0);
    cycle(4'hF, 1'b0);
    chk("resume_level", obs_level, 15);
    chk("resume_gnt", obs_gnt, 4'b1000);
    cycle(4'hF, 1'b0);
    chk("refull_gnt", obs_gnt, 0);
    chk("refull_level", obs_level, 16);

    // drain to 5, then simultaneous write and read
    repeat (11) cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b1);
    chk("simul_gnt", obs_gnt, 4'b0001);
    chk("simul_lvl_pre", obs_level, 5);
    cycle(4'b0000, 1'b0);
    chk("simul_lvl_post", obs_level, 5);

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic rd;
      r = N'($urandom);
      rd = ($urandom_range(0, 99) < 45) && (m_level > 0);
      cycle(r, rd);
    end

    for (int i = 0; i < 20; i++) cycle(4'b0000, m_level > 0);
    chk("drained", obs_level, 0);
    chk("pre_uf_err", obs_err, 0);

    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("uf_level", obs_level, 0);
    chk("uf_err", obs_err, 1);
    repeat (3) cycle(4'b0100, 1'b0);
    chk("uf_err_sticky", obs_err, 1);
    repeat (5) cycle(4'b0000, 1'b1);

    // reset while owner 2 is mid-burst at beat 2
    do_reset();
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    chk("mid_gnt", obs_gnt, 4'b0100);
    do_reset();
    cycle(4'b0100, 1'b0);
    chk("post_rst_gnt", obs_gnt, 4'b0100);
    chk("post_rst_err", obs_err, 0);
    cycle(4'b0000, 1'b0);
    do_reset();
    cycle(4'b1111, 1'b0);
    chk("post_rst_rr0", obs_gnt, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
